// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and
// the mode encoding used by the iterative multiply/divide engine.
package alu_pkg;

  localparam logic [3:0] OP_ADD      = 4'd1;
  localparam logic [3:0] OP_SUB      = 4'd2;
  localparam logic [3:0] OP_MUL      = 4'd3;
  localparam logic [3:0] OP_MOD      = 4'd4;
  localparam logic [3:0] OP_PASSATOC = 4'd5;
  localparam logic [3:0] OP_PASSBTOC = 4'd6;
  localparam logic [3:0] OP_INCAC    = 4'd7;
  localparam logic [3:0] OP_DECAC    = 4'd8;
  localparam logic [3:0] OP_RESET    = 4'd9;
  localparam logic [3:0] OP_DIV      = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER
  } state_t;

  localparam logic [1:0] MD_MUL = 2'd0;
  localparam logic [1:0] MD_DIV = 2'd1;
  localparam logic [1:0] MD_MOD = 2'd2;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic [1:0] op_mode(input logic [3:0] op);
    logic [1:0] m;
    case (op)
      OP_DIV:  m = MD_DIV;
      OP_MOD:  m = MD_MOD;
      default: m = MD_MUL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative engine: shift-add multiply and restoring divide, one bit per
// cycle, WIDTH iterations counted down from WIDTH-1 to 0.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             dz,
  output logic             last
);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] breg;
  logic             dz_r;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sreg_nxt;
  logic [WIDTH-1:0] breg_nxt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // acc is the product accumulator (MUL) or partial remainder (DIV/MOD);
  // sreg holds the multiplier or the dividend shifting out / quotient in.
  always_comb begin
    acc_nxt  = acc;
    sreg_nxt = sreg;
    breg_nxt = breg;
    rem_sh   = '0;
    diff     = '0;
    if (mode_r == MD_MUL) begin
      if (sreg[0]) acc_nxt = acc + breg;
      breg_nxt = breg << 1;
      sreg_nxt = sreg >> 1;
    end else begin
      rem_sh = {acc, sreg[WIDTH-1]};
      diff   = rem_sh - {1'b0, breg};
      if (!diff[WIDTH]) begin
        acc_nxt  = diff[WIDTH-1:0];
        sreg_nxt = {sreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt  = rem_sh[WIDTH-1:0];
        sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mode_r <= MD_MUL;
      acc    <= '0;
      sreg   <= '0;
      breg   <= '0;
      dz_r   <= 1'b0;
      last   <= 1'b0;
    end else begin
      last <= 1'b0;
      if (load) begin
        busy   <= 1'b1;
        cnt    <= CNT_W'(WIDTH - 1);
        mode_r <= mode;
        acc    <= '0;
        sreg   <= (mode == MD_MUL) ? b : a;
        breg   <= (mode == MD_MUL) ? a : b;
        dz_r   <= (mode != MD_MUL) && (b == '0);
      end else if (busy) begin
        acc  <= acc_nxt;
        sreg <= sreg_nxt;
        breg <= breg_nxt;
        if (cnt == '0) begin
          busy <= 1'b0;
          last <= 1'b1;
        end else begin
          cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Divide by zero still runs full length; the result is forced here.
  always_comb begin
    case (mode_r)
      MD_DIV:  result = dz_r ? '1 : sreg;
      MD_MOD:  result = dz_r ? '0 : acc;
      default: result = acc;
    endcase
  end

  assign dz = dz_r;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with start/done handshake; single-cycle ops finish in one
// cycle, MUL/DIV/MOD in WIDTH+1 cycles via alu_muldiv_seq.
//   state | meaning
//   IDLE  | ready, waiting for start
//   EXEC  | single-cycle op, result written on next edge
//   ITER  | waiting for the iterative engine to finish
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a_bus,
  input  logic [WIDTH-1:0] b_bus,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] c_bus,
  output logic             z_flag,
  output logic             c_flag,
  output logic             dz_flag
);

  state_t           state, state_nxt;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;

  logic             done_nxt;
  logic             wr_c;
  logic [WIDTH-1:0] c_nxt;
  logic             z_nxt, cf_nxt, dz_nxt;
  logic             seq_load;
  logic [WIDTH-1:0] seq_result;
  logic             seq_dz;
  logic             seq_last;

  logic [WIDTH:0]   sum_w, dif_w, inc_w, dec_w;
  localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

  alu_muldiv_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk    (clk),
    .rst    (rst),
    .load   (seq_load),
    .mode   (op_mode(control)),
    .a      (a_bus),
    .b      (b_bus),
    .result (seq_result),
    .dz     (seq_dz),
    .last   (seq_last)
  );

  assign ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    seq_load  = 1'b0;
    wr_c      = 1'b0;
    c_nxt     = c_bus;
    z_nxt     = z_flag;
    cf_nxt    = c_flag;
    dz_nxt    = dz_flag;
    sum_w     = {1'b0, a_r} + {1'b0, b_r};
    dif_w     = {1'b0, a_r} - {1'b0, b_r};
    inc_w     = {1'b0, a_r} + ONE_W;
    dec_w     = {1'b0, a_r} - ONE_W;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_iter_op(control)) begin
            state_nxt = ITER;
            seq_load  = 1'b1;
          end else begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        wr_c      = 1'b1;
        dz_nxt    = 1'b0;
        case (op_r)
          OP_ADD:      {cf_nxt, c_nxt} = sum_w;
          OP_SUB:      {cf_nxt, c_nxt} = dif_w;
          OP_INCAC:    {cf_nxt, c_nxt} = inc_w;
          OP_DECAC:    {cf_nxt, c_nxt} = dec_w;
          OP_PASSATOC: c_nxt = a_r;
          OP_PASSBTOC: c_nxt = b_r;
          OP_RESET:    c_nxt = '0;
          default: begin
            // undefined op: handshake only, architectural state untouched
            wr_c   = 1'b0;
            dz_nxt = dz_flag;
          end
        endcase
      end
      ITER: begin
        if (seq_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          wr_c      = 1'b1;
          c_nxt     = seq_result;
          dz_nxt    = seq_dz;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (wr_c) z_nxt = (c_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      c_bus   <= '0;
      z_flag  <= 1'b0;
      c_flag  <= 1'b0;
      dz_flag <= 1'b0;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
    end else begin
      state   <= state_nxt;
      done    <= done_nxt;
      c_bus   <= c_nxt;
      z_flag  <= z_nxt;
      c_flag  <= cf_nxt;
      dz_flag <= dz_nxt;
      if (state == IDLE && start) begin
        op_r <= control;
        a_r  <= a_bus;
        b_r  <= b_bus;
      end
    end
  end

endmodule
